// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: the pipeline WB stage has priority, and
// multi-cycle results drain from a small FIFO when WB is idle.
module regfile_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb_valid,
  input  logic [ADDR_W-1:0]          wb_rd,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       ml_valid,
  output logic                       ml_ready,
  input  logic [ADDR_W-1:0]          ml_rd,
  input  logic [DATA_W-1:0]          ml_data,
  input  logic [ADDR_W-1:0]          query_reg1,
  input  logic [ADDR_W-1:0]          query_reg2,
  output logic                       pending1,
  output logic                       pending2,
  output logic                       RegWrite,
  output logic [ADDR_W-1:0]          Write_register,
  output logic [DATA_W-1:0]          Write_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  live_q;
  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic full;
  logic wb_fire;
  logic ml_fire;
  logic push;
  logic pop;

  // ML handshake: a transfer happens in any cycle where ml_valid && ml_ready
  // are both high at posedge; ml_ready does not depend on ml_valid.
  assign full     = (count == CNT_W'(DEPTH));
  assign ml_ready = !full && !reset;
  assign wb_fire  = wb_valid && (wb_rd != '0);
  assign ml_fire  = ml_valid && ml_ready;
  assign push     = ml_fire && (ml_rd != '0);
  assign pop      = !wb_fire && (count != '0);

  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= ml_rd;
      data_mem[wr_ptr] <= ml_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      live_q         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      RegWrite       <= 1'b0;
      Write_register <= '0;
      Write_data     <= '0;
    end else begin
      // WB is younger than every queued result, so it kills same-rd entries.
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_fire && (rd_mem[i] == wb_rd)) live_q[i] <= 1'b0;
      end
      if (pop) begin
        live_q[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        live_q[wr_ptr] <= !(wb_fire && (ml_rd == wb_rd));
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end

      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);

      if (wb_fire) begin
        RegWrite       <= 1'b1;
        Write_register <= wb_rd;
        Write_data     <= wb_data;
      end else if (pop) begin
        RegWrite       <= live_q[rd_ptr];
        Write_register <= rd_mem[rd_ptr];
        Write_data     <= data_mem[rd_ptr];
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

  // A slot's live bit is only ever set while it is occupied.
  always_comb begin
    pending1 = 1'b0;
    pending2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (rd_mem[i] == query_reg1)) pending1 = 1'b1;
      if (live_q[i] && (rd_mem[i] == query_reg2)) pending2 = 1'b1;
    end
    if (RegWrite && (Write_register == query_reg1)) pending1 = 1'b1;
    if (RegWrite && (Write_register == query_reg2)) pending2 = 1'b1;
    if (query_reg1 == '0) pending1 = 1'b0;
    if (query_reg2 == '0) pending2 = 1'b0;
  end

endmodule
